// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared types and helpers for the push-button front end.
//               Per-channel FSM state encoding and counter-width helper.
// Revision    : 1.0  initial release
// ============================================================================
package btn_pkg;

    // Per-channel debounce / hold state, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEB_DN = 2'd1,
        HELD   = 2'd2,
        DEB_UP = 2'd3
    } btn_state_t;

    // Width that holds the largest of the three tick counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : btn_ctrl_if
// Description : Signal bundle of the push-button front end.
//               ce1ms       1 ms clock-enable strobe
//               btn_in      raw asynchronous buttons, 1 = pressed
//               btn_lvl     debounced level
//               btn_press   1-clk press strobe
//               btn_release 1-clk release strobe
//               btn_long    1-clk long-press strobe
//               slave  : the btn_ctrl side, master : the driving side.
// Revision    : 1.0  initial release
// ============================================================================
interface btn_ctrl_if #(
    parameter int N_BTN = 4
);
    logic             ce1ms;
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_lvl;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;

    modport slave (
        input  ce1ms,
        input  btn_in,
        output btn_lvl,
        output btn_press,
        output btn_release,
        output btn_long
    );

    modport master (
        output ce1ms,
        output btn_in,
        input  btn_lvl,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );
endinterface
`default_nettype wire

// File: rtl/btn_chan.sv
`default_nettype none
// ============================================================================
// Module      : btn_chan
// Description : One button channel: 2-flop synchroniser, debounce/hold FSM,
//               registered level and press/release/long strobes.
//               Optional macro BTN_REPEAT_EN: auto-repeat press strobes every
//               REP_MS ticks after the long-press strobe while held.
// Ports       : clk, rst       clock, synchronous active-high reset
//               i_ce1ms        1 ms tick enable
//               i_btn          raw button input
//               o_lvl          debounced level
//               o_press        press strobe (also repeat strobes)
//               o_release      release strobe
//               o_long         long-press strobe
// Revision    : 1.0  initial release
// ============================================================================
module btn_chan
    import btn_pkg::*;
#(
    parameter int DEB_MS  = 20,
    parameter int LONG_MS = 1000,
    parameter int REP_MS  = 200
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_ce1ms,
    input  wire logic i_btn,
    output logic      o_lvl,
    output logic      o_press,
    output logic      o_release,
    output logic      o_long
);

    localparam int                 c_CNT_W    = cnt_width(DEB_MS, LONG_MS, REP_MS);
    localparam logic [c_CNT_W-1:0] c_DEB_LAST = c_CNT_W'(DEB_MS - 1);
    localparam logic [c_CNT_W-1:0] c_LONG_MAX = c_CNT_W'(LONG_MS);
`ifdef BTN_REPEAT_EN
    localparam logic [c_CNT_W-1:0] c_REP_LAST = c_CNT_W'(REP_MS - 1);
    localparam bit                 c_LONG_EN  = (LONG_MS > 0);
`endif

    btn_state_t         r_state;
    logic               r_meta;
    logic               r_sync;
    logic [c_CNT_W-1:0] r_deb_cnt;
    logic [c_CNT_W-1:0] r_hold_cnt;
`ifdef BTN_REPEAT_EN
    logic [c_CNT_W-1:0] r_rep_cnt;
`endif
    logic               r_lvl;
    logic               r_press;
    logic               r_release;
    logic               r_long;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_meta     <= 1'b0;
            r_sync     <= 1'b0;
            r_deb_cnt  <= '0;
            r_hold_cnt <= '0;
`ifdef BTN_REPEAT_EN
            r_rep_cnt  <= '0;
`endif
            r_lvl      <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_meta    <= i_btn;
            r_sync    <= r_meta;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;

            // A level change on r_sync is checked before the tick so that a
            // coincident tick is never counted in the state being left.
            case (r_state)
                IDLE: begin
                    if (r_sync) begin
                        r_state   <= DEB_DN;
                        r_deb_cnt <= '0;
                    end
                end

                DEB_DN: begin
                    if (!r_sync) begin
                        r_state <= IDLE;
                    end else if (i_ce1ms) begin
                        if (r_deb_cnt == c_DEB_LAST) begin
                            r_state    <= HELD;
                            r_hold_cnt <= '0;
`ifdef BTN_REPEAT_EN
                            r_rep_cnt  <= '0;
`endif
                            r_lvl      <= 1'b1;
                            r_press    <= 1'b1;
                        end else begin
                            r_deb_cnt <= r_deb_cnt + 1'b1;
                        end
                    end
                end

                HELD: begin
                    if (!r_sync) begin
                        r_state   <= DEB_UP;
                        r_deb_cnt <= '0;
                    end else if (i_ce1ms) begin
                        // Saturating at LONG_MS makes btn_long a one-shot per
                        // press, even across bounces through DEB_UP.
                        if (r_hold_cnt != c_LONG_MAX) begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                            if (r_hold_cnt == c_LONG_MAX - 1'b1)
                                r_long <= 1'b1;
                        end
`ifdef BTN_REPEAT_EN
                        else if (c_LONG_EN) begin
                            if (r_rep_cnt == c_REP_LAST) begin
                                r_rep_cnt <= '0;
                                r_press   <= 1'b1;
                            end else begin
                                r_rep_cnt <= r_rep_cnt + 1'b1;
                            end
                        end
`endif
                    end
                end

                DEB_UP: begin
                    if (r_sync) begin
                        r_state <= HELD;
                    end else if (i_ce1ms) begin
                        if (r_deb_cnt == c_DEB_LAST) begin
                            r_state   <= IDLE;
                            r_lvl     <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_deb_cnt <= r_deb_cnt + 1'b1;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_lvl     = r_lvl;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule
`default_nettype wire

// File: rtl/btn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : btn_ctrl
// Description : Multi-channel push-button front end. Fans the 1 ms tick out
//               to N_BTN independent btn_chan instances and gathers their
//               level and strobe outputs.
//               Optional macro BTN_REPEAT_EN: auto-repeat of btn_press.
// Ports       : clk   system clock
//               rst   synchronous active-high reset
//               bus   btn_ctrl_if.slave (ce1ms, btn_in, btn_lvl, btn_press,
//                     btn_release, btn_long)
// Revision    : 1.0  initial release
// ============================================================================
module btn_ctrl #(
    parameter int N_BTN   = 4,
    parameter int DEB_MS  = 20,
    parameter int LONG_MS = 1000,
    parameter int REP_MS  = 200
) (
    input  wire logic  clk,
    input  wire logic  rst,
    btn_ctrl_if.slave  bus
);

    logic [N_BTN-1:0] w_lvl;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_release;
    logic [N_BTN-1:0] w_long;

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_chan
            btn_chan #(
                .DEB_MS  (DEB_MS),
                .LONG_MS (LONG_MS),
                .REP_MS  (REP_MS)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .i_ce1ms   (bus.ce1ms),
                .i_btn     (bus.btn_in[i]),
                .o_lvl     (w_lvl[i]),
                .o_press   (w_press[i]),
                .o_release (w_release[i]),
                .o_long    (w_long[i])
            );
        end
    endgenerate

    assign bus.btn_lvl     = w_lvl;
    assign bus.btn_press   = w_press;
    assign bus.btn_release = w_release;
    assign bus.btn_long    = w_long;

endmodule
`default_nettype wire
